mcycle_alu: RTL and testbench



---
 rtl/mcycle_alu.sv | 155 +++++++++++++++
 tb/tb_mcycle_alu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_alu.sv
// Iterative multiply (shift-add) / divide (restoring) unit with Start/Busy/Done handshake.
// Optional MCYCLE_SIGNED_EN enables signed operation via MCycleOp[1].
module mcycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       ResultFlags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic               div_q;
  logic [WIDTH-1:0]   m_q, hi, lo;
  logic               accept, last;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0]   hi_n, lo_n, mag1, mag2, quo, rem, res1, res2;
  logic [2*WIDTH-1:0] prod;

`ifdef MCYCLE_SIGNED_EN
  logic s1, s2, neg_d, rem_neg_d, neg_q, rem_neg_q;

  always_comb begin
    s1   = MCycleOp[1] & Operand1[WIDTH-1];
    s2   = MCycleOp[1] & Operand2[WIDTH-1];
    mag1 = s1 ? -Operand1 : Operand1;
    mag2 = s2 ? -Operand2 : Operand2;
    // Divide by zero keeps the all-ones quotient un-negated; the remainder
    // fixup then restores the latched dividend from its magnitude.
    neg_d     = MCycleOp[0] ? ((s1 ^ s2) & (|Operand2)) : (s1 ^ s2);
    rem_neg_d = MCycleOp[0] & s1;
  end
`else
  logic unused_sign;
  assign unused_sign = MCycleOp[1];

  always_comb begin
    mag1 = Operand1;
    mag2 = Operand2;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    Busy    = 1'b0;
    Done    = 1'b0;
    accept  = 1'b0;
    last    = (cnt == LAST);
    case (state)
      IDLE: begin
        accept = Start;
        if (Start) state_n = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        accept  = Start;
        state_n = Start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // One iteration: hi/lo hold partial product or remainder/quotient.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        hi_n = div_diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_sh[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = {hi_n, lo_n};
    quo  = lo_n;
    rem  = hi_n;
`ifdef MCYCLE_SIGNED_EN
    if (neg_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (rem_neg_q) rem = -rem;
`endif
    res1 = div_q ? quo : prod[WIDTH-1:0];
    res2 = div_q ? rem : prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt         <= '0;
      div_q       <= 1'b0;
      m_q         <= '0;
      hi          <= '0;
      lo          <= '0;
      Result1     <= '0;
      Result2     <= '0;
      ResultFlags <= 2'b01;
`ifdef MCYCLE_SIGNED_EN
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      div_q <= MCycleOp[0];
      hi    <= '0;
      m_q   <= MCycleOp[0] ? mag2 : mag1;
      lo    <= MCycleOp[0] ? mag1 : mag2;
`ifdef MCYCLE_SIGNED_EN
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
`endif
    end else if (state == RUN) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        Result1     <= res1;
        Result2     <= res2;
        ResultFlags <= {res1[WIDTH-1], res1 == '0};
      end
    end
  end

endmodule

// File: tb/tb_mcycle_alu.sv
// Scoreboard testbench for mcycle_alu: table vectors, random vectors and handshake corner cases.
module tb_mcycle_alu;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET, Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1, Operand2, Result1, Result2;
  logic         Busy, Done;
  logic [1:0]   ResultFlags;

  always #5 CLK = ~CLK;

  mcycle_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1), .Result2(Result2),
    .Busy(Busy), .Done(Done), .ResultFlags(ResultFlags)
  );

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a, b, r1, r2;
  } vec_t;

  typedef struct {
    logic [W-1:0] r1, r2;
    logic [1:0]   fl;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [W-1:0] r1, input logic [W-1:0] r2);
    exp_t e;
    e.r1 = r1;
    e.r2 = r2;
    e.fl = {r1[W-1], r1 == '0};
    return e;
  endfunction

  // Unsigned reference model.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (!op[0]) begin
      p = 64'(a) * 64'(b);
      return mk(p[W-1:0], p[2*W-1:W]);
    end
    if (b == '0) return mk('1, a);
    return mk(a / b, a % b);
  endfunction

  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    @(posedge CLK);
    #1;
    Start    = 1'b0;
    MCycleOp = 2'($urandom_range(0, 3));
    Operand1 = $urandom;
    Operand2 = $urandom;
  endtask

  // Counts negedges after the accepting edge (n0 already elapsed) until Done.
  task automatic wait_done(input string name, input int n0);
    int   n = n0;
    bit   seen = 0;
    bit   busy_ok = 1;
    exp_t e;
    while (n < 3 * W) begin
      @(negedge CLK);
      n++;
      if (Done) begin
        seen = 1;
        break;
      end
      if (!Busy) busy_ok = 0;
    end
    check({name, " latency"}, seen ? n : 0, W + 1);
    check({name, " busy"}, {busy_ok, Busy}, 2'b10);
    if (seen) begin
      check({name, " sb"}, sb.size(), 1 + ((sb.size() > 1) ? sb.size() - 1 : 0));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({name, " r1"}, Result1, e.r1);
        check({name, " r2"}, Result2, e.r2);
        check({name, " flags"}, ResultFlags, e.fl);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
    sb.push_back(e);
    drive(op, a, b);
    wait_done(name, 0);
    @(negedge CLK);
    check({name, " hold"}, {Done, Busy, Result1, Result2}, {2'b00, e.r1, e.r2});
  endtask

  initial begin
    RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;

    tbl.push_back('{"mul max*2",  2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001});
    tbl.push_back('{"mul zero",   2'b00, 32'h00000000, 32'h00001234, 32'h00000000, 32'h00000000});
    tbl.push_back('{"mul max^2",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE});
    tbl.push_back('{"div 100/7",  2'b01, 32'd100,      32'd7,        32'd14,       32'd2});
    tbl.push_back('{"div 5/0",    2'b01, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5});
    tbl.push_back('{"div 7/9",    2'b01, 32'd7,        32'd9,        32'd0,        32'd7});
    tbl.push_back('{"div max/1",  2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0});
`ifdef MCYCLE_SIGNED_EN
    tbl.push_back('{"smul -3*5",  2'b10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF});
    tbl.push_back('{"sdiv -7/2",  2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF});
    tbl.push_back('{"sdiv min/-1",2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0});
    tbl.push_back('{"sdiv -5/0",  2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB});
    tbl.push_back('{"sdiv 7/-2",  2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1});
`else
    tbl.push_back('{"udiv op11",  2'b11, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1});
    tbl.push_back('{"umul op10",  2'b10, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'h00000004});
`endif

    repeat (3) @(negedge CLK);
    check("reset state", {Busy, Done, Result1, Result2, ResultFlags},
          {2'b00, 32'h0, 32'h0, 2'b01});
    RESET = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, mk(tbl[i].r1, tbl[i].r2));

    for (int i = 0; i < 6; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      a = $urandom;
      b = (i == 5) ? '0 : ((i % 2) ? W'($urandom_range(1, 1000)) : $urandom);
      op = {1'b0, 1'(i % 2)};
`ifndef MCYCLE_SIGNED_EN
      op[1] = 1'($urandom_range(0, 1));
`endif
      run_op("random", op, a, b, model(op, a, b));
    end

    // Start re-pulsed with new operands mid-run must be ignored.
    sb.push_back(mk(32'd14, 32'd2));
    drive(2'b01, 32'd100, 32'd7);
    repeat (4) @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd3;
    repeat (4) @(negedge CLK);
    Start = 1'b0;
    wait_done("midrun", 8);
    @(negedge CLK);

    // Start held through DONE launches a second operation back-to-back.
    sb.push_back(mk(32'd42, 32'd0));
    sb.push_back(mk(32'd33, 32'd1));
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd6; Operand2 = 32'd7;
    @(posedge CLK);
    #1;
    MCycleOp = 2'b01; Operand1 = 32'd100; Operand2 = 32'd3;
    wait_done("b2b first", 0);
    @(posedge CLK);
    #1;
    Start = 1'b0;
    wait_done("b2b second", 0);
    @(negedge CLK);

    // Reset mid-run discards the operation.
    sb.push_back(mk(32'd1, 32'd0));
    drive(2'b00, 32'd1, 32'd1);
    repeat (9) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("reset midrun", {Busy, Done, Result1, Result2, ResultFlags},
          {2'b00, 32'h0, 32'h0, 2'b01});
    RESET = 1'b0;
    sb.delete();
    begin
      bit seen = 0;
      for (int i = 0; i < W + 5; i++) begin
        @(negedge CLK);
        if (Done || Busy) seen = 1;
      end
      check("no done after reset", seen, 0);
    end
    run_op("after reset", 2'b01, 32'd1000, 32'd10, mk(32'd100, 32'd0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
